// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, one iteration per clock on a (WIDTH+1)-bit datapath.
// Handles signed or unsigned operands by extending them one bit before recoding.
module booth_mult_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 sgn,
    input  logic [WIDTH-1:0]     mc,
    input  logic [WIDTH-1:0]     mp,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned CW = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [WIDTH:0]     a_q, a_d;
    logic [WIDTH:0]     q_q, q_d;
    logic [WIDTH:0]     m_q, m_d;
    logic               q1_q, q1_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     a_sh, q_sh;
    logic               q1_sh;

    always_comb begin
        unique case ({q_q[0], q1_q})
            2'b01:   sum = a_q + m_q;
            2'b10:   sum = a_q - m_q;
            default: sum = a_q;
        endcase
        // Arithmetic shift of {A,Q,Q_1}, sign taken from the post-add accumulator.
        {a_sh, q_sh, q1_sh} = {sum[WIDTH], sum, q_q};
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        q_d       = q_q;
        m_d       = m_q;
        q1_d      = q1_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StRun;
                    m_d     = sgn ? {mc[WIDTH-1], mc} : {1'b0, mc};
                    q_d     = sgn ? {mp[WIDTH-1], mp} : {1'b0, mp};
                    a_d     = '0;
                    q1_d    = 1'b0;
                    cnt_d   = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                a_d   = a_sh;
                q_d   = q_sh;
                q1_d  = q1_sh;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH)) begin
                    state_d   = StDone;
                    product_d = {a_sh[WIDTH-2:0], q_sh};
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            a_q       <= '0;
            q_q       <= '0;
            m_q       <= '0;
            q1_q      <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            q_q       <= q_d;
            m_q       <= m_d;
            q1_q      <= q1_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q == StRun);
    assign done    = (state_q == StDone);
    assign product = product_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq at WIDTH=8, plus a WIDTH=16 back-to-back random run
// against a behavioural multiply model.
module tb_booth_mult_seq;

    logic        clk;
    logic        reset;
    logic        start8, sgn8;
    logic [7:0]  mc8, mp8;
    logic        busy8, done8;
    logic [15:0] product8;
    logic        start16, sgn16;
    logic [15:0] mc16, mp16;
    logic        busy16, done16;
    logic [31:0] product16;

    int errors = 0;
    int checks = 0;

    booth_mult_seq #(.WIDTH(8)) u_dut8 (
        .clk     (clk),
        .reset   (reset),
        .start   (start8),
        .sgn     (sgn8),
        .mc      (mc8),
        .mp      (mp8),
        .busy    (busy8),
        .done    (done8),
        .product (product8)
    );

    booth_mult_seq #(.WIDTH(16)) u_dut16 (
        .clk     (clk),
        .reset   (reset),
        .start   (start16),
        .sgn     (sgn16),
        .mc      (mc16),
        .mp      (mp16),
        .busy    (busy16),
        .done    (done16),
        .product (product16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref16(input logic s, input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] sa, sb;
        if (s) begin
            sa = 32'(signed'(a));
            sb = 32'(signed'(b));
            return 32'(sa * sb);
        end
        return {16'h0, a} * {16'h0, b};
    endfunction

    // One isolated 8-bit operation: latency, result, and a single-cycle done pulse.
    task automatic run8(input string tag, input logic s, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp);
        int n;
        sgn8 = s; mc8 = a; mp8 = b; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        check({tag, "_busy"}, 64'(busy8), 64'(1));
        n = 0;
        while (!done8 && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'(9));
        check({tag, "_prod"}, 64'(product8), 64'(exp));
        tick();
        check({tag, "_pulse"}, 64'(done8), 64'(0));
    endtask

    initial begin
        int n, pulses;
        logic [31:0] prev_exp, cur_exp, nxt_exp;
        logic        nxt_s;
        logic [15:0] nxt_a, nxt_b;

        reset = 1'b1;
        start8 = 1'b0; sgn8 = 1'b0; mc8 = '0; mp8 = '0;
        start16 = 1'b0; sgn16 = 1'b0; mc16 = '0; mp16 = '0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_busy", 64'(busy8), 64'(0));
        check("rst_done", 64'(done8), 64'(0));
        check("rst_prod", 64'(product8), 64'(0));
        check("rst_busy16", 64'(busy16), 64'(0));

        run8("neg3x5", 1'b1, 8'hFD, 8'h05, 16'hFFF1);
        run8("ffxff_u", 1'b0, 8'hFF, 8'hFF, 16'hFE01);
        run8("ffxff_s", 1'b1, 8'hFF, 8'hFF, 16'h0001);
        run8("minxmin", 1'b1, 8'h80, 8'h80, 16'h4000);
        run8("minxmax", 1'b1, 8'h80, 8'h7F, 16'hC080);
        run8("maxxmax", 1'b1, 8'h7F, 8'h7F, 16'h3F01);
        run8("200x100", 1'b0, 8'hC8, 8'h64, 16'h4E20);

        // Start during RUN must be ignored.
        sgn8 = 1'b0; mc8 = 8'h03; mp8 = 8'h07; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        mc8 = 8'h55; mp8 = 8'h55; sgn8 = 1'b1; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (done8) begin
                pulses++;
                check("ign_prod", 64'(product8), 64'h15);
            end
            tick();
        end
        check("ign_pulses", 64'(pulses), 64'(1));

        // Reset four cycles into RUN aborts with no done pulse.
        sgn8 = 1'b0; mc8 = 8'h05; mp8 = 8'h06; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", 64'(busy8), 64'(0));
        check("abort_done", 64'(done8), 64'(0));
        check("abort_prod", 64'(product8), 64'(0));
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            if (done8) pulses++;
            tick();
        end
        check("abort_pulses", 64'(pulses), 64'(0));
        run8("after_rst", 1'b1, 8'h07, 8'hFA, 16'hFFD6);

        // WIDTH=16 back-to-back run with start held high throughout.
        prev_exp = 32'h0;
        nxt_s = 1'($urandom); nxt_a = 16'($urandom); nxt_b = 16'($urandom);
        sgn16 = nxt_s; mc16 = nxt_a; mp16 = nxt_b; start16 = 1'b1;
        cur_exp = ref16(nxt_s, nxt_a, nxt_b);
        tick();
        for (int i = 0; i < 1000; i++) begin
            nxt_s = 1'($urandom); nxt_a = 16'($urandom); nxt_b = 16'($urandom);
            if (i % 10 == 0) nxt_a = 16'h8000;
            sgn16 = nxt_s; mc16 = nxt_a; mp16 = nxt_b;
            nxt_exp = ref16(nxt_s, nxt_a, nxt_b);
            check("b2b_busy", 64'(busy16), 64'(1));
            tick();
            check("b2b_hold", 64'(product16), 64'(prev_exp));
            n = 1;
            while (!done16 && n < 40) begin
                tick();
                n++;
            end
            check("b2b_lat", 64'(n), 64'(17));
            check("b2b_prod", 64'(product16), 64'(cur_exp));
            prev_exp = cur_exp;
            cur_exp = nxt_exp;
            tick();
        end
        start16 = 1'b0;
        n = 0;
        while (!done16 && n < 40) begin
            tick();
            n++;
        end
        check("last_prod", 64'(product16), 64'(cur_exp));
        tick();
        check("idle_busy16", 64'(busy16), 64'(0));
        check("idle_done16", 64'(done16), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
